regfile_port_scheduler: RTL
===========================

# regfile_port_scheduler

Shares the single write port and single read port of the team's 16x16 pipelined register file among `NUM_REQ` requesters. Each port has an independent round-robin arbiter. Read data is returned one cycle after the grant, tagged with the requester ID. A built-in clear sequencer zeroes the whole file on command. The block sits directly between the requesters (core datapath, debug, DMA) and the register file's `write_enable`/`write_address`/`data_in`/`read_address`/`data_out` pins.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `ADDR_W`, 4: register address width; file depth is 2^ADDR_W
- `DATA_W`, 16: register data width
- `ID_W`, $clog2(NUM_REQ): requester ID width

Ports:
- `clk` in 1: single clock; all state updates on its rising edge
- `reset` in 1: synchronous, active-high
- `wr_req` in NUM_REQ: per-requester write request
- `wr_addr` in NUM_REQ*ADDR_W: flattened write addresses; requester i occupies slice i
- `wr_data` in NUM_REQ*DATA_W: flattened write data
- `wr_gnt` out NUM_REQ: one-hot write grant; the write is accepted in the cycle `wr_gnt` is high
- `rd_req` in NUM_REQ: per-requester read request
- `rd_addr` in NUM_REQ*ADDR_W: flattened read addresses
- `rd_gnt` out NUM_REQ: one-hot read grant
- `rd_rsp_valid` out 1: read response valid
- `rd_rsp_id` out ID_W: index of the requester that owns the response
- `rd_rsp_data` out DATA_W: read response data
- `clear_start` in 1: pulse that starts a full-file clear
- `busy` out 1: clear in progress
- `rf_write_enable` out 1: to register file
- `rf_write_address` out ADDR_W: to register file
- `rf_data_in` out DATA_W: to register file
- `rf_read_address` out ADDR_W: to register file
- `rf_data_out` in DATA_W: from register file; registered there, so valid one cycle after the address

## Operation
- **FSM states:**
  - IDLE → CLEAR on `clear_start`.
  - CLEAR → IDLE after address 2^ADDR_W−1 is written.
  - `clear_start` is ignored while in CLEAR.
- **CLEAR:**
  - Drives `rf_write_enable`=1, `rf_data_in`=0, and `rf_write_address` from an internal counter that runs 0..2^ADDR_W−1, one address per cycle.
  - `wr_gnt`=0 and `rd_gnt`=0 for the whole state.
  - `busy`=1.
- **IDLE arbitration:**
  - Each port grants the first requesting index at or after its pointer, searching upward modulo NUM_REQ.
  - When a grant is issued, that port's pointer becomes granted index + 1 (mod NUM_REQ).
  - A pointer holds its value in any cycle with no grant on its port.
- **Grant timing:** `wr_gnt`/`rd_gnt` are combinational from the requests and the pointer in the same cycle. Requesters hold req/addr/data until granted.
- **Register-file drive:**
  - `rf_write_enable` = |`wr_gnt`.
  - Address and data are muxed from the granted slice.
  - `rf_read_address` is muxed from the granted read slice; it is 0 when no read is granted.
- **Read response:**
  - On a read grant, the granted ID is registered.
  - Next cycle: `rd_rsp_valid`=1, `rd_rsp_id` = that ID, `rd_rsp_data` = `rf_data_out`.
- **Read/write same cycle:**
  - A read and a write granted in the same cycle to the same address return the OLD value, because the register file's registered read samples before the write lands.
  - The exception is `REGFILE_SCHED_BYPASS_EN` (see Configuration).
- **Reset:**
  - All grants and `rf_*` outputs are 0 while `reset` is high.
  - `rd_rsp_valid`=0, `rd_rsp_id`=0, `busy`=0.
  - Both pointers = 0; state = IDLE; clear counter = 0.
  - Reset during CLEAR aborts the clear immediately.

## Timing
- Write latency: the write is visible in the file on the clock edge at the end of the grant cycle.
- Read latency: response in grant cycle + 1. Back-to-back read grants give back-to-back responses, one per cycle, throughput 1.
- Clear: `clear_start` in cycle N → `busy` high in cycles N+1..N+2^ADDR_W (16 cycles at the default). First grant is possible in cycle N+2^ADDR_W+1.
- If `clear_start` and requests arrive in the same IDLE cycle, the requests are granted that cycle and CLEAR begins on the next cycle.
- A read granted in the cycle before CLEAR still returns its response during the first CLEAR cycle.

## Configuration
- `REGFILE_SCHED_BYPASS_EN` defined:
  - A comparator registers a match flag when a granted read address equals the write address driven in the same cycle (a granted write or a clear write).
  - It also registers the written data.
  - The response then returns the NEW data, or 0 for a clear.
- Undefined: no comparator; the response is always `rf_data_out` (old-value semantics).

## Test plan
- Reset, then all 4 requesters assert `wr_req` continuously → `wr_gnt` sequence 0001, 0010, 0100, 1000, 0001; each `wr_data`=16'hA000+i lands at its `wr_addr`.
- Only requester 2 reads addr 5 holding 16'h1234 → `rd_gnt`=0100; next cycle `rd_rsp_valid`=1, `rd_rsp_id`=2, `rd_rsp_data`=16'h1234.
- Write addr 3=16'hBEEF and read addr 3 (old value 16'h0001) in the same cycle → response 16'h0001 without the macro, 16'hBEEF with `REGFILE_SCHED_BYPASS_EN`.
- Fill the file with nonzero data, pulse `clear_start` with requests pending → `busy` high for exactly 16 cycles with no grants; afterwards reads of addresses 0..15 all return 0 and pending requests are granted.
- Assert `reset` at clear cycle 7 → next cycle `busy`=0, grants resume; addresses 7..15 keep their prior data.
- Requester 1 requests alone repeatedly, then requester 0 joins → requester 0 is granted the next cycle (pointer at 2 wraps to 0), then requester 1.

Source files
------------

// File: rtl/regfile_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : regfile_port_scheduler
// Purpose  : Shares the single write port and single read port of a pipelined
//            register file among NUM_REQ requesters using two independent
//            round-robin arbiters. Read data returns one cycle after the grant,
//            tagged with the requester ID. A clear sequencer zeroes the whole
//            file on command.
// Ports    : clk, reset (sync, active-high)
//            wr_req/wr_addr/wr_data -> wr_gnt       write requesters
//            rd_req/rd_addr         -> rd_gnt       read requesters
//            rd_rsp_valid/rd_rsp_id/rd_rsp_data     read response
//            clear_start -> busy                    full-file clear
//            rf_write_enable/rf_write_address/rf_data_in/rf_read_address,
//            rf_data_out                            register-file pins
// Options  : REGFILE_SCHED_BYPASS_EN - same-cycle write-to-read forwarding
// Revision : 1.0 - initial release
// ============================================================================
module regfile_port_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 16,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         wr_req,
    input  logic [NUM_REQ*ADDR_W-1:0]  wr_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  wr_data,
    output logic [NUM_REQ-1:0]         wr_gnt,
    input  logic [NUM_REQ-1:0]         rd_req,
    input  logic [NUM_REQ*ADDR_W-1:0]  rd_addr,
    output logic [NUM_REQ-1:0]         rd_gnt,
    output logic                       rd_rsp_valid,
    output logic [ID_W-1:0]            rd_rsp_id,
    output logic [DATA_W-1:0]          rd_rsp_data,
    input  logic                       clear_start,
    output logic                       busy,
    output logic                       rf_write_enable,
    output logic [ADDR_W-1:0]          rf_write_address,
    output logic [DATA_W-1:0]          rf_data_in,
    output logic [ADDR_W-1:0]          rf_read_address,
    input  logic [DATA_W-1:0]          rf_data_out
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ID_W-1:0]   c_LAST_ID   = ID_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [ID_W-1:0]     r_wr_ptr;
    logic [ID_W-1:0]     r_rd_ptr;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;

    logic                w_arb_en;
    logic                w_wr_found;
    logic                w_rd_found;
    logic [ID_W-1:0]     w_wr_idx;
    logic [ID_W-1:0]     w_rd_idx;
    logic                w_wr_grant;
    logic                w_rd_grant;

    // Returns {found, index} of the first request at or after ptr, wrapping
    // modulo NUM_REQ.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    ptr);
        logic          found;
        logic [ID_W-1:0] idx;
        int            cand;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = ID_W'(cand);
            end
        end
        return {found, idx};
    endfunction

    assign {w_wr_found, w_wr_idx} = rr_pick(wr_req, r_wr_ptr);
    assign {w_rd_found, w_rd_idx} = rr_pick(rd_req, r_rd_ptr);

    // Arbitration only runs in IDLE and never while reset is asserted.
    assign w_arb_en   = (r_state == ST_IDLE) && !reset;
    assign w_wr_grant = w_arb_en && w_wr_found;
    assign w_rd_grant = w_arb_en && w_rd_found;

    assign wr_gnt = w_wr_grant ? (NUM_REQ'(1) << w_wr_idx) : '0;
    assign rd_gnt = w_rd_grant ? (NUM_REQ'(1) << w_rd_idx) : '0;

    // Next-state and register-file drive
    always_comb begin
        w_state_nxt      = r_state;
        rf_write_enable  = 1'b0;
        rf_write_address = '0;
        rf_data_in       = '0;
        rf_read_address  = '0;
        case (r_state)
            ST_IDLE: begin
                if (clear_start) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (r_clr_cnt == c_LAST_ADDR) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (!reset) begin
            if (r_state == ST_CLEAR) begin
                rf_write_enable  = 1'b1;
                rf_write_address = r_clr_cnt;
            end else if (w_wr_grant) begin
                rf_write_enable  = 1'b1;
                rf_write_address = wr_addr[w_wr_idx*ADDR_W +: ADDR_W];
                rf_data_in       = wr_data[w_wr_idx*DATA_W +: DATA_W];
            end
            if (w_rd_grant) begin
                rf_read_address = rd_addr[w_rd_idx*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_clr_cnt   <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            // The counter wraps to 0 on the last clear write, ready for the
            // next clear.
            if (r_state == ST_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
            if (w_wr_grant) begin
                r_wr_ptr <= (w_wr_idx == c_LAST_ID) ? '0 : w_wr_idx + 1'b1;
            end
            if (w_rd_grant) begin
                r_rd_ptr <= (w_rd_idx == c_LAST_ID) ? '0 : w_rd_idx + 1'b1;
                r_rsp_id <= w_rd_idx;
            end
            r_rsp_valid <= w_rd_grant;
        end
    end

    assign busy         = (r_state == ST_CLEAR) && !reset;
    assign rd_rsp_valid = r_rsp_valid && !reset;
    assign rd_rsp_id    = reset ? '0 : r_rsp_id;

`ifdef REGFILE_SCHED_BYPASS_EN
    // The file's registered read samples before a same-cycle write lands, so
    // capture the written value and substitute it in the response.
    logic              r_byp_hit;
    logic [DATA_W-1:0] r_byp_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_byp_hit  <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_byp_hit  <= w_rd_grant && rf_write_enable &&
                          (rf_read_address == rf_write_address);
            r_byp_data <= rf_data_in;
        end
    end

    assign rd_rsp_data = r_byp_hit ? r_byp_data : rf_data_out;
`else
    assign rd_rsp_data = rf_data_out;
`endif

endmodule
`default_nettype wire
